// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-port signals shared by the two cache miss paths and the arbiter.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_done, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, mem_req, mem_wr, mem_addr, mem_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_done, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, mem_req, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes I-side and D-side cache misses onto one memory port, D priority with I starvation guard.
module mem_arbiter #(
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus,
  output logic [15:0] i_grant_cnt,
  output logic [15:0] d_grant_cnt
);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;
  state_t state, nxt;
  logic [2:0] streak;
  logic grant_i, grant_d, wr_q;
  logic starve;
  assign starve = streak == 3'(STARVE_LIM);
  always_comb begin
    nxt = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state)
      IDLE: begin
        grant_d = bus.d_req && !(bus.i_req && starve);
        grant_i = bus.i_req && !grant_d;
        nxt = grant_d ? BUSY_D : grant_i ? BUSY_I : IDLE;
      end
      BUSY_I: nxt = bus.mem_done ? RESP_I : BUSY_I;
      BUSY_D: nxt = bus.mem_done ? RESP_D : BUSY_D;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // Outputs decoded from state only, so reset clears them without a clock edge.
  assign bus.mem_req = state == BUSY_I || state == BUSY_D;
  assign bus.mem_wr  = wr_q && state == BUSY_D;
  assign bus.i_done  = state == RESP_I;
  assign bus.d_done  = state == RESP_D;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q          <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      streak        <= '0;
      i_grant_cnt   <= '0;
      d_grant_cnt   <= '0;
    end else begin
      if (grant_i) begin
        wr_q         <= 1'b0;
        bus.mem_addr <= bus.i_addr;
        streak       <= '0;
        if (i_grant_cnt != 16'hFFFF) i_grant_cnt <= i_grant_cnt + 16'd1;
      end
      if (grant_d) begin
        wr_q          <= bus.d_wr;
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
        if (bus.i_req && !starve) streak <= streak + 3'd1;
        if (d_grant_cnt != 16'hFFFF) d_grant_cnt <= d_grant_cnt + 16'd1;
      end
      if (state == BUSY_I && bus.mem_done) bus.i_rdata <= bus.mem_rdata;
      if (state == BUSY_D && bus.mem_done && !wr_q) bus.d_rdata <= bus.mem_rdata;
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single unified memory port between the instruction-cache miss path and the data-cache miss/write path. It sits between the cache controllers and the memory module inside `proc_hier`. It serializes one transaction at a time. Data side has priority, with a starvation guard for the instruction side. It also exports saturating grant counters for perf logging.

## Interface
- `STARVE_LIM`, default 4: maximum number of consecutive D grants made while `i_req` is pending before I is forced.
- `AW`, default 16: address width.
- `DW`, default 16: data width.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `i_req`  in  1: I-side read request; held until `i_done`.
- `i_addr`  in  AW: I-side address; stable while `i_req` is high.
- `i_done`  out  1: one-cycle pulse; `i_rdata` is valid.
- `i_rdata`  out  DW: registered read data for I.
- `d_req`  in  1: D-side request; held until `d_done`.
- `d_wr`  in  1: 1 = write, 0 = read; stable while `d_req` is high.
- `d_addr`  in  AW: D address.
- `d_wdata`  in  DW: D write data.
- `d_done`  out  1: one-cycle completion pulse.
- `d_rdata`  out  DW: registered read data for D.
- `mem_req`  out  1: memory transaction active.
- `mem_wr`  out  1: memory write enable.
- `mem_addr`  out  AW: latched address.
- `mem_wdata`  out  DW: latched write data.
- `mem_done`  in  1: memory completion; sampled only while `mem_req` is high.
- `mem_rdata`  in  DW: memory read data; valid with `mem_done`.
- `i_grant_cnt`  out  16: count of I grants, saturating at 0xFFFF.
- `d_grant_cnt`  out  16: count of D grants, saturating at 0xFFFF.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- **IDLE:**
  - No request: stay in IDLE.
  - Only one request: grant that side.
  - Both requesting: grant D, unless `streak == STARVE_LIM`, in which case grant I.
- **Grant action:** on the granting edge, latch addr/wr/wdata into the `mem_*` registers and go to BUSY_x.
  - I grants always have `mem_wr=0` and `mem_wdata` held unchanged.
- **Streak counter:** 3 bits.
  - Increments, saturating at `STARVE_LIM`, on a D grant made while `i_req` is high.
  - Clears on any I grant.
  - Unchanged on a D grant made while `i_req` is low.
- **BUSY_x:**
  - `mem_req=1`.
  - On an edge where `mem_done` is high: capture `mem_rdata` into `x_rdata` (reads only; a D write leaves `d_rdata` unchanged), then go to RESP_x.
  - Otherwise stay in BUSY_x.
- **RESP_x:** `x_done=1` for exactly this cycle, `mem_req=0`, then go to IDLE unconditionally.
  - No request is accepted in RESP.
  - Requesters drop `req` at the edge that ends RESP.
- **Grant counters:** increment on each grant edge. Saturate, never wrap.
- **Protocol violations:**
  - `req` dropped while that side is BUSY: the transaction still completes and `done` still pulses.
  - `mem_done` outside BUSY: ignored.
- **Reset** (async, any state, including mid-transaction): go to IDLE immediately, with `mem_req`, `mem_wr`, `i_done`, `d_done` = 0.
  - `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata`, streak, and both counters = 0.
  - An in-flight memory result arriving after reset is ignored.

## Timing
- All outputs are registered or decoded from FSM state only. There is no combinational path from any `*_req` or `mem_done` to any output.
- **Latency:** request seen in IDLE at cycle 0.
  - `mem_req` is high from cycle 1.
  - Memory asserts `mem_done` in cycle 1+k (k≥0).
  - `x_done` is high in cycle 2+k.
  - The arbiter is back in IDLE in cycle 3+k.
  - Minimum request-to-done latency is 2 cycles; minimum back-to-back spacing is 3 cycles.
- `mem_addr`, `mem_wr`, and `mem_wdata` are stable for the whole BUSY interval.
- A request arriving during BUSY or RESP waits. It is evaluated in IDLE with the priority rule above.

## Test plan
- **Single I read:** `i_req=1`, `i_addr=0x0040`, memory returns `0xA5A5` with k=0.
  - `mem_req` is high in cycle 1 only; `i_done` and `i_rdata=0xA5A5` in cycle 2; `i_grant_cnt=1`.
- **D write:** `d_wr=1`, `d_addr=0x1000`, `d_wdata=0x1234`, k=3.
  - `mem_wr=1`, `mem_addr=0x1000`, `mem_wdata=0x1234` for cycles 1–4; `d_done` in cycle 5; `d_rdata` unchanged.
- **Simultaneous requests from IDLE:** D is granted first. I is granted in the next IDLE.
  - Both counters end at 1; streak = 0 at the end.
- **Starvation:** hold `i_req` and `d_req` high continuously, k=0.
  - Grant order is D,D,D,D,I,D,D,D,D,I.
  - `d_grant_cnt=8`, `i_grant_cnt=2`.
- **Reset mid-op:** assert `rst` during BUSY_D with k=5.
  - All outputs are 0 within the same cycle, with no clock edge required.
  - A `mem_done` pulse after release of reset produces no `d_done`.
- **Counter saturation:** force `d_grant_cnt` to 0xFFFE, then perform two D grants.
  - Reads 0xFFFF after each grant; no wrap to 0.
